// File: rtl/cnn_seq_pkg.sv
// cnn_seq_pkg: state encoding, frame-size helper and timeout class
// shared by the CNN frame sequencer and its counter.
package cnn_seq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRST     = 3'd1,
    STREAM   = 3'd2,
    WAIT_RES = 3'd3,
    EMIT     = 3'd4
  } seq_state_e;

  // All-ones decision reported on timeout; truncate to the class width.
  localparam logic [31:0] TIMEOUT_CLASS = '1;

  function automatic int img_pixels(input int w, input int h);
    return w * h;
  endfunction

endpackage

// File: rtl/cnn_seq_counter.sv
// cnn_seq_counter: up-counter with clear (priority), enable and
// terminal-count flag. Ports: clk, rst_n, clr_i, en_i -> cnt_o, tc_o.
module cnn_seq_counter
  import cnn_seq_pkg::*;
#(
  parameter int W   = 8,
  parameter int MAX = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  localparam logic [W-1:0] MAX_C = W'(MAX);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == MAX_C);

endmodule

// File: rtl/cnn_frame_sequencer.sv
// cnn_frame_sequencer: per-frame pipeline reset, pixel streaming,
// bounded wait for the comparator result and tagged decision output.
// Inputs: start/abort/num_frames run control, pix_rdata from memory,
// res_valid/res_class from the comparator.
// Outputs: pix_rd_en/pix_addr/frame_idx memory side, pix_out/pix_valid
// to conv1, pipe_rst_n, dec_* decision, busy/done/timeout_err status.
module cnn_frame_sequencer
  import cnn_seq_pkg::*;
#(
  parameter int IMG_W           = 28,
  parameter int IMG_H           = 28,
  parameter int PIX_BITS        = 8,
  parameter int ADDR_BITS       = 10,
  parameter int CLASS_BITS      = 4,
  parameter int FRAME_BITS      = 8,
  parameter int PIPE_RST_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 4095
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [FRAME_BITS-1:0] num_frames,
  output logic                  pix_rd_en,
  output logic [ADDR_BITS-1:0]  pix_addr,
  output logic [FRAME_BITS-1:0] frame_idx,
  input  logic [PIX_BITS-1:0]   pix_rdata,
  output logic [PIX_BITS-1:0]   pix_out,
  output logic                  pix_valid,
  output logic                  pipe_rst_n,
  input  logic                  res_valid,
  input  logic [CLASS_BITS-1:0] res_class,
  output logic                  dec_valid,
  output logic [CLASS_BITS-1:0] dec_class,
  output logic [FRAME_BITS-1:0] dec_frame,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err
);

  localparam int NPIX = img_pixels(IMG_W, IMG_H);
  localparam int PW   = $clog2(PIPE_RST_CYCLES + 1);
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CLASS_BITS-1:0] TO_CLASS =
    CLASS_BITS'(TIMEOUT_CLASS);

  seq_state_e state_q, state_d;

  logic [FRAME_BITS-1:0] num_q, num_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [FRAME_BITS-1:0] frame_inc;
  logic [CLASS_BITS-1:0] cls_q, cls_d;
  logic                  terr_q, terr_d;
  logic                  zdone_q, zdone_d;
  logic                  prst_n_q, prst_n_d;
  logic                  pv_q;
  logic [PIX_BITS-1:0]   pix_q;

  logic                  kill;
  logic                  last_frame;
  logic                  in_prst;
  logic                  in_strm;
  logic                  in_wait;
  logic                  in_emit;
  logic                  prst_tc;
  logic                  addr_tc;
  logic                  to_tc;
  logic [PW-1:0]         prst_cnt_unused;
  logic [TW-1:0]         to_cnt_unused;

  assign in_prst    = (state_q == PRST);
  assign in_strm    = (state_q == STREAM);
  assign in_wait    = (state_q == WAIT_RES);
  assign in_emit    = (state_q == EMIT);
  assign kill       = abort && (state_q != IDLE);
  assign frame_inc  = frame_q + 1'b1;
  assign last_frame = (frame_inc == num_q);

  cnn_seq_counter #(
    .W   (PW),
    .MAX (PIPE_RST_CYCLES - 1)
  ) u_prst_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (!in_prst || prst_tc || kill),
    .en_i  (in_prst),
    .cnt_o (prst_cnt_unused),
    .tc_o  (prst_tc)
  );

  // Cleared on the last address so pix_addr rests at 0 between frames.
  cnn_seq_counter #(
    .W   (ADDR_BITS),
    .MAX (NPIX - 1)
  ) u_addr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (!in_strm || addr_tc || kill),
    .en_i  (in_strm),
    .cnt_o (pix_addr),
    .tc_o  (addr_tc)
  );

  cnn_seq_counter #(
    .W   (TW),
    .MAX (TIMEOUT_CYCLES - 1)
  ) u_to_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (!in_wait || kill),
    .en_i  (in_wait),
    .cnt_o (to_cnt_unused),
    .tc_o  (to_tc)
  );

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    frame_d = frame_q;
    cls_d   = cls_q;
    terr_d  = terr_q;
    zdone_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (num_frames == '0) begin
            zdone_d = 1'b1;
          end else begin
            num_d   = num_frames;
            frame_d = '0;
            terr_d  = 1'b0;
            state_d = PRST;
          end
        end
      end
      PRST: begin
        if (prst_tc) state_d = STREAM;
      end
      STREAM: begin
        if (addr_tc) state_d = WAIT_RES;
      end
      WAIT_RES: begin
        // A result on the final cycle still wins over the timeout.
        if (res_valid) begin
          cls_d   = res_class;
          state_d = EMIT;
        end else if (to_tc) begin
          cls_d   = TO_CLASS;
          terr_d  = 1'b1;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (last_frame) begin
          state_d = IDLE;
        end else begin
          frame_d = frame_inc;
          state_d = PRST;
        end
      end
      default: state_d = IDLE;
    endcase
    if (kill) begin
      state_d = IDLE;
      num_d   = num_q;
      frame_d = frame_q;
      cls_d   = cls_q;
      terr_d  = terr_q;
    end
  end

  // Pipeline is released only on the edge that enters STREAM and
  // stays released through WAIT_RES and EMIT.
  always_comb begin
    prst_n_d = 1'b0;
    unique case (state_d)
      STREAM, WAIT_RES, EMIT: prst_n_d = 1'b1;
      default:                prst_n_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      num_q    <= '0;
      frame_q  <= '0;
      cls_q    <= '0;
      terr_q   <= 1'b0;
      zdone_q  <= 1'b0;
      prst_n_q <= 1'b0;
      pv_q     <= 1'b0;
      pix_q    <= '0;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      frame_q  <= frame_d;
      cls_q    <= cls_d;
      terr_q   <= terr_d;
      zdone_q  <= zdone_d;
      prst_n_q <= prst_n_d;
      pv_q     <= pix_rd_en;
      if (pix_rd_en) pix_q <= pix_rdata;
    end
  end

  assign pix_rd_en   = in_strm && !kill;
  assign pix_valid   = pv_q && !kill;
  assign pix_out     = pix_q;
  assign pipe_rst_n  = prst_n_q && !kill;
  assign frame_idx   = frame_q;
  assign dec_valid   = in_emit && !kill;
  assign dec_class   = cls_q;
  assign dec_frame   = frame_q;
  assign busy        = (state_q != IDLE);
  assign done        = (in_emit && last_frame && !kill) || zdone_q;
  assign timeout_err = terr_q;

endmodule
